// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI shift front end and the burst RAM.
// PAY_W is derived here so both ends agree on the received word width.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int PAY_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [PAY_W+1:0]  din;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              addr_err;
  logic              clr_err;

  modport master (
    output din, rx_valid, clr_err,
    input  dout, tx_valid, addr_err
  );

  modport slave (
    input  din, rx_valid, clr_err,
    output dout, tx_valid, addr_err
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Opcode-driven single-port RAM behind an SPI slave: address loads, writes and
// registered reads with independent, optionally auto-incrementing pointers.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit AUTO_INC  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  spi_ram_burst_if.slave bus
);
  localparam int PAY_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int IDX_W = (MEM_DEPTH > 2) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } op_e;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              we;

  op_e               op;
  logic [PAY_W-1:0]  pay;
  logic [ADDR_W-1:0] addr_pl;
  logic [DATA_W-1:0] data_pl;

  assign op      = op_e'(bus.din[PAY_W+1:PAY_W]);
  assign pay     = bus.din[PAY_W-1:0];
  assign addr_pl = pay[ADDR_W-1:0];
  assign data_pl = pay[DATA_W-1:0];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // Wrap at the configured depth, not at 2**ADDR_W, so odd depths work.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    addr_err_d = addr_err_q & ~bus.clr_err;
    we         = 1'b0;
    if (bus.rx_valid) begin
      unique case (op)
        OP_SET_WADDR: begin
          if (in_range(addr_pl)) wr_ptr_d = addr_pl;
          else                   addr_err_d = 1'b1;
        end
        OP_WRITE: begin
          we = 1'b1;
          if (AUTO_INC) wr_ptr_d = ptr_next(wr_ptr_q);
        end
        OP_SET_RADDR: begin
          if (in_range(addr_pl)) rd_ptr_d = addr_pl;
          else                   addr_err_d = 1'b1;
        end
        OP_READ: begin
          dout_d     = mem[rd_ptr_q[IDX_W-1:0]];
          tx_valid_d = 1'b1;
          if (AUTO_INC) rd_ptr_d = ptr_next(rd_ptr_q);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage is never reset; reset only blocks a write presented on its edge.
  always_ff @(posedge clk) begin
    if (!rst && we) mem[wr_ptr_q[IDX_W-1:0]] <= data_pl;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: a 256-deep and a 100-deep instance, with
// expected read data queued at issue time and checked by a tx_valid monitor.
module tb_spi_ram_burst;
  localparam logic [1:0] SETW = 2'b00;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] SETR = 2'b10;
  localparam logic [1:0] RD   = 2'b11;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  spi_ram_burst_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  spi_ram_burst_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(100), .AUTO_INC(1'b1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each tx_valid pulse must match the oldest queued read
  // both in data and in the cycle it was due.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.tx_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_tx", 8'd1, 8'd0);
      else begin
        e = qa.pop_front();
        chk("a_rd_data", ifa.dout, e.data);
        chk("a_rd_cycle", 8'(cyc), 8'(e.cyc));
      end
    end
    if (ifb.tx_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_tx", 8'd1, 8'd0);
      else begin
        e = qb.pop_front();
        chk("b_rd_data", ifb.dout, e.data);
        chk("b_rd_cycle", 8'(cyc), 8'(e.cyc));
      end
    end
  end

  // One clock of stimulus to DUT b (0 = 256-deep, 1 = 100-deep). A READ's
  // payload is don't-care to the DUT, so it carries the expected byte here.
  task automatic step(input bit b, input bit v, input logic [1:0] op,
                      input logic [7:0] pay, input bit clr, input bit r);
    @(negedge clk);
    rst = r;
    ifa.rx_valid = 1'b0; ifa.clr_err = 1'b0;
    ifb.rx_valid = 1'b0; ifb.clr_err = 1'b0;
    if (!b) begin
      ifa.din = {op, pay}; ifa.rx_valid = v; ifa.clr_err = clr;
      if (v && !r && op == RD) qa.push_back('{pay, cyc + 1});
    end else begin
      ifb.din = {op, pay}; ifb.rx_valid = v; ifb.clr_err = clr;
      if (v && !r && op == RD) qb.push_back('{pay, cyc + 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input bit b, input logic [1:0] op, input logic [7:0] pay);
    step(b, 1'b1, op, pay, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    ifa.din = '0; ifa.rx_valid = 1'b0; ifa.clr_err = 1'b0;
    ifb.din = '0; ifb.rx_valid = 1'b0; ifb.clr_err = 1'b0;

    step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    chk("a_rst_dout", ifa.dout, 8'h00);
    chk("a_rst_tx", {7'd0, ifa.tx_valid}, 8'h00);
    chk("a_rst_err", {7'd0, ifa.addr_err}, 8'h00);
    chk("b_rst_dout", ifb.dout, 8'h00);
    chk("b_rst_tx", {7'd0, ifb.tx_valid}, 8'h00);
    chk("b_rst_err", {7'd0, ifb.addr_err}, 8'h00);
    idle(1);

    // Memory survives reset; rd_ptr=0 after reset reads mem[0].
    cmd(0, SETW, 8'h00); cmd(0, WR, 8'h5C);
    step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    cmd(0, RD, 8'h5C);
    idle(2);

    cmd(0, SETW, 8'h10); cmd(0, WR, 8'hA5);
    cmd(0, SETR, 8'h10); cmd(0, RD, 8'hA5);
    idle(2);

    // Burst across the top of a 256-deep memory.
    cmd(0, SETW, 8'hFE); cmd(0, WR, 8'h11); cmd(0, WR, 8'h22); cmd(0, WR, 8'h33);
    cmd(0, SETR, 8'hFE); cmd(0, RD, 8'h11); cmd(0, RD, 8'h22); cmd(0, RD, 8'h33);
    idle(2);

    // A WRITE with rx_valid low must leave memory and wr_ptr alone.
    cmd(0, SETW, 8'h20); cmd(0, WR, 8'h44);
    step(1'b0, 1'b0, WR, 8'h77, 1'b0, 1'b0);
    cmd(0, WR, 8'h55);
    cmd(0, SETR, 8'h20); cmd(0, RD, 8'h44); cmd(0, RD, 8'h55);
    idle(2);

    // Reset in the middle of a burst, with a READ presented on the reset edge.
    cmd(0, SETW, 8'h05); cmd(0, WR, 8'hC1); cmd(0, WR, 8'hC2);
    step(1'b0, 1'b1, RD, 8'h00, 1'b0, 1'b1);
    chk("a_midrst_tx", {7'd0, ifa.tx_valid}, 8'h00);
    chk("a_midrst_dout", ifa.dout, 8'h00);
    cmd(0, WR, 8'hD0);
    cmd(0, RD, 8'hD0);
    cmd(0, SETR, 8'h05); cmd(0, RD, 8'hC1); cmd(0, RD, 8'hC2);
    idle(2);
    chk("a_err_never", {7'd0, ifa.addr_err}, 8'h00);

    // 100-deep instance: wrap at 99 and range checks.
    cmd(1, SETW, 8'd99); cmd(1, WR, 8'hB1); cmd(1, WR, 8'hB2);
    cmd(1, SETR, 8'd99); cmd(1, RD, 8'hB1); cmd(1, RD, 8'hB2);
    cmd(1, SETW, 8'd5); cmd(1, WR, 8'h3C); cmd(1, SETR, 8'd5);
    chk("b_err_clear_before", {7'd0, ifb.addr_err}, 8'h00);
    cmd(1, SETR, 8'd100);
    chk("b_err_set_100", {7'd0, ifb.addr_err}, 8'h01);
    cmd(1, RD, 8'h3C);
    chk("b_err_sticky", {7'd0, ifb.addr_err}, 8'h01);
    step(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    chk("b_err_cleared", {7'd0, ifb.addr_err}, 8'h00);
    step(1'b1, 1'b1, SETR, 8'd200, 1'b1, 1'b0);
    chk("b_err_set_wins", {7'd0, ifb.addr_err}, 8'h01);
    step(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    chk("b_err_cleared2", {7'd0, ifb.addr_err}, 8'h00);
    idle(3);

    chk("a_reads_outstanding", 8'(qa.size()), 8'd0);
    chk("b_reads_outstanding", 8'(qb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end
endmodule
